// File: rtl/p2s_pkg.sv
// Shared types and helpers for the parallel-to-serial LED chain driver.
// Optional parity bit is enabled by defining P2S_PARITY_EN.
package p2s_pkg;

  // Frame sequencing: wait for start, shift the bits out, strobe the latch.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Width of the sclk half-period counter; sized for CLK_DIV up to 255.
  localparam int unsigned DIV_CNT_W = 8;

  // Ceiling log2 for elaboration-time sizing of counters.
  function automatic int unsigned p2s_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/p2s_clkdiv.sv
// Bit-period divider: CLK_DIV cycles with sclk low, then CLK_DIV cycles
// with sclk high. Held cleared while en is low so every frame starts at
// the beginning of a low half-period.
module p2s_clkdiv
  import p2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase,     // 1 during the sclk-high half of the bit period
  output logic bit_tick,  // last cycle of a bit period; next cycle starts a new bit
  output logic low_end    // last cycle of a low half-period
);

  localparam logic [DIV_CNT_W-1:0] HALF_LAST = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic                 half_end;

  assign half_end = (cnt_q == HALF_LAST);

  // Count cycles within a half-period and flip phase at each half boundary.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (half_end) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase    = phase_q;
  assign bit_tick = en && half_end && phase_q;
  assign low_end  = en && half_end && !phase_q;

endmodule

// File: rtl/par2ser_led_drv.sv
// Parallel-to-serial driver for an LED shift-register chain: shifts a
// captured word out on sdata/sclk, then pulses sen to latch the chain.
// Define P2S_PARITY_EN to append an odd-parity bit after the data bits.
module par2ser_led_drv
  import p2s_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] P_in,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sdata,
  output logic             sen
);

`ifdef P2S_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  localparam int unsigned NBITS = WIDTH + PAR_BITS;
  localparam int unsigned CNT_W = p2s_clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;

  logic [NBITS-1:0] load_word;
  logic [NBITS-1:0] shifted;
  logic             tap;
  logic             div_en;
  logic             div_phase;
  logic             bit_tick;
  logic             low_end;

`ifdef P2S_PARITY_EN
  // Odd parity: the extra bit is 1 when the word holds an even number of ones.
  logic par_bit;
  assign par_bit = ~^P_in;
`endif

  // Shift direction and load layout: the bit sent first sits at the tap end,
  // and the parity bit (when present) sits at the far end so it goes last.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign tap     = sr_q[NBITS-1];
      assign shifted = {sr_q[NBITS-2:0], 1'b0};
`ifdef P2S_PARITY_EN
      assign load_word = {P_in, par_bit};
`else
      assign load_word = P_in;
`endif
    end else begin : g_lsb_first
      assign tap     = sr_q[0];
      assign shifted = {1'b0, sr_q[NBITS-1:1]};
`ifdef P2S_PARITY_EN
      assign load_word = {par_bit, P_in};
`else
      assign load_word = P_in;
`endif
    end
  endgenerate

  assign div_en = (state_q != IDLE);

  p2s_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .clk      (clk),
    .rst      (rst),
    .en       (div_en),
    .phase    (div_phase),
    .bit_tick (bit_tick),
    .low_end  (low_end)
  );

  // Next-state logic: capture on start, advance one bit per period, latch.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d      = load_word;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            sr_d      = '0;
            bit_cnt_d = '0;
            state_d   = LATCH;
          end else begin
            sr_d      = shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      LATCH: begin
        // Leaving LATCH lands in IDLE with done high, so a start in the
        // done cycle is accepted immediately.
        if (low_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, shift register and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

  // Outputs decoded from registered state only; sclk and sdata are quiet
  // outside SHIFT so the chain sees clean idle and latch phases.
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign sclk  = (state_q == SHIFT) && div_phase;
  assign sdata = (state_q == SHIFT) && tap;
  assign sen   = (state_q == LATCH);

endmodule

// File: tb/tb_par2ser_led_drv.sv
// Bench for par2ser_led_drv: an MSB-first and an LSB-first instance run side
// by side. Expected bits are queued when a frame is started and popped on
// each sclk rising edge. Honours P2S_PARITY_EN when defined.
module tb_par2ser_led_drv;

  localparam int W = 16;
  localparam int D = 2;
`ifdef P2S_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int BUSY_LEN = NB * 2 * D + D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] p_in;
  logic [1:0]   busy_v, done_v, sclk_v, sdata_v, sen_v;

  always #5 clk = ~clk;

  par2ser_led_drv #(.WIDTH(W), .CLK_DIV(D), .MSB_FIRST(1)) dut_msb (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .P_in  (p_in),
    .busy  (busy_v[0]),
    .done  (done_v[0]),
    .sclk  (sclk_v[0]),
    .sdata (sdata_v[0]),
    .sen   (sen_v[0])
  );

  par2ser_led_drv #(.WIDTH(W), .CLK_DIV(D), .MSB_FIRST(0)) dut_lsb (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .P_in  (p_in),
    .busy  (busy_v[1]),
    .done  (done_v[1]),
    .sclk  (sclk_v[1]),
    .sdata (sdata_v[1]),
    .sen   (sen_v[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  bit   exp_q0[$];
  bit   exp_q1[$];
  int   done_count = 0;
  logic abort = 1'b0;

  // Monitor: sample away from the rising edge.
  logic [1:0] sclk_p = '0, busy_p = '0, sen_p = '0;
  logic [1:0] hold_bit = '0;
  int busy_cnt[2] = '{0, 0};
  int sen_cnt[2]  = '{0, 0};
  int bit_cnt[2]  = '{0, 0};

  always @(negedge clk) begin
    bit e;
    for (int i = 0; i < 2; i++) begin
      if (sclk_v[i] && !sclk_p[i]) begin
        e = 1'b0;
        if (i == 0) begin
          if (exp_q0.size() == 0) check("queue_underflow_msb", 1, 0);
          else e = exp_q0.pop_front();
        end else begin
          if (exp_q1.size() == 0) check("queue_underflow_lsb", 1, 0);
          else e = exp_q1.pop_front();
        end
        check($sformatf("sdata_dut%0d_bit%0d", i, bit_cnt[i]), sdata_v[i], e);
        $display("dut%0d bit %0d sdata=%0b exp=%0b", i, bit_cnt[i], sdata_v[i], e);
        hold_bit[i] = sdata_v[i];
        bit_cnt[i]++;
      end else if (sclk_v[i]) begin
        check($sformatf("sdata_stable_dut%0d", i), sdata_v[i], hold_bit[i]);
      end

      if (sen_v[i]) begin
        check($sformatf("sen_sclk_low_dut%0d", i), sclk_v[i], 0);
        sen_cnt[i]++;
      end else if (sen_p[i]) begin
        check($sformatf("sen_len_dut%0d", i), sen_cnt[i], D);
        sen_cnt[i] = 0;
      end

      if (busy_v[i]) begin
        busy_cnt[i]++;
      end else if (busy_p[i]) begin
        if (!abort) check($sformatf("busy_len_dut%0d", i), busy_cnt[i], BUSY_LEN);
        busy_cnt[i] = 0;
      end

      if (done_v[i]) begin
        check($sformatf("done_at_busy_fall_dut%0d", i), {busy_p[i], busy_v[i]}, 2'b10);
        check($sformatf("frame_bits_dut%0d", i), bit_cnt[i], NB);
        $display("dut%0d frame done bits=%0d", i, bit_cnt[i]);
        if (i == 0) done_count++;
        bit_cnt[i] = 0;
      end else if (!busy_v[i]) begin
        bit_cnt[i] = 0;
        sen_cnt[i] = 0;
      end
    end
    if (busy_v == 2'b00) abort = 1'b0;
    sclk_p = sclk_v;
    busy_p = busy_v;
    sen_p  = sen_v;
  end

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) exp_q0.push_back(d[i]);
    for (int i = 0; i < W; i++) exp_q1.push_back(d[i]);
`ifdef P2S_PARITY_EN
    exp_q0.push_back(~^d);
    exp_q1.push_back(~^d);
`endif
  endtask

  task automatic send(input logic [W-1:0] d);
    start = 1'b1;
    p_in  = d;
    push_frame(d);
    $display("start frame P_in=%04h", d);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while (!done_v[0] && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_v[0], 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy_v,  2'b00);
    check({tag, "_done"},  done_v,  2'b00);
    check({tag, "_sclk"},  sclk_v,  2'b00);
    check({tag, "_sdata"}, sdata_v, 2'b00);
    check({tag, "_sen"},   sen_v,   2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [W-1:0] w;

    // Reset with start held: start must be ignored.
    rst   = 1'b1;
    start = 1'b1;
    p_in  = '1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_during_rst_ignored", busy_v, 2'b00);
    repeat (2) @(negedge clk);

    // Reference frame 16'hAA55.
    d0 = done_count;
    send(16'hAA55);
    check("busy_after_accept", busy_v, 2'b11);
    check("first_bit_msb", sdata_v[0], 1'b1);
    check("first_bit_lsb", sdata_v[1], 1'b1);
    wait_done(200);
    @(negedge clk);
    check("done_one_cycle", done_v, 2'b00);
    check("one_done_pulse", done_count - d0, 1);

    // Random words.
    for (int k = 0; k < 3; k++) begin
      w = W'($urandom);
      send(w);
      wait_done(200);
      @(negedge clk);
    end

    // Start re-asserted mid-frame with different data: ignored.
    send(16'h3C5A);
    repeat (8) @(negedge clk);
    start = 1'b1;
    p_in  = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    start = 1'b1;
    p_in  = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    @(negedge clk);
    check("idle_after_ignored_starts", busy_v, 2'b00);
    repeat (3) @(negedge clk);

    // Reset mid-frame.
    send(16'h0F0F);
    repeat (18) @(negedge clk);
    abort = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    check_all_zero("midframe_rst");
    d0 = done_count;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", done_count - d0, 0);
    send(16'hC3A5);
    wait_done(200);
    @(negedge clk);

    // Start held across done: back-to-back frames with no idle gap.
    start = 1'b1;
    p_in  = 16'h8001;
    push_frame(16'h8001);
    $display("start frame P_in=%04h (held)", p_in);
    @(negedge clk);
    wait_done(200);
    p_in = 16'h7E11;
    push_frame(16'h7E11);
    $display("start frame P_in=%04h (back-to-back)", p_in);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy_v, 2'b11);
    check("b2b_first_bit_msb", sdata_v[0], 1'b0);
    check("b2b_first_bit_lsb", sdata_v[1], 1'b1);
    wait_done(200);
    @(negedge clk);
    check("queue_drained", exp_q0.size() + exp_q1.size(), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/par2ser_led_drv.md
PAR2SER_LED_DRV -- requirements
Module: par2ser_led_drv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the parallel word width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter CLK_DIV, default 2, meaning clk cycles per sclk half-period (legal range 1..255).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning shift order (1 = bit WIDTH-1 first; 0 = bit 0 first).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to transmit P_in.
REQ-007 The block SHALL have port P_in, input, WIDTH bits: the parallel data word.
REQ-008 The block SHALL have port busy, output, 1 bit: transfer in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port sclk, output, 1 bit: serial shift clock to the LED shift-register chain.
REQ-011 The block SHALL have port sdata, output, 1 bit: serial data.
REQ-012 The block SHALL have port sen, output, 1 bit: latch strobe to the LED chain.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and LATCH.
REQ-014 The block SHALL accept start only in IDLE; on the accept cycle it SHALL capture P_in, go to SHIFT and assert busy from the next cycle.
REQ-015 Start asserted while busy SHALL be ignored; P_in changes after capture SHALL have no effect.
REQ-016 Each bit period SHALL last 2*CLK_DIV cycles: sclk=0 for the first CLK_DIV cycles and sclk=1 for the next CLK_DIV cycles.
REQ-017 sdata SHALL update only at the start of a bit period (sclk low) and SHALL be stable while sclk is high.
REQ-018 The first bit SHALL appear on sdata in the cycle after start is accepted.
REQ-019 Bit order SHALL follow MSB_FIRST; the internal shift register SHALL shift once per bit period.
REQ-020 After the last bit period the FSM SHALL enter LATCH: sen=1 and sclk=0 for CLK_DIV cycles.
REQ-021 On leaving LATCH the block SHALL return to IDLE, deassert busy and pulse done for exactly one cycle.
REQ-022 busy SHALL remain high for exactly NBITS*2*CLK_DIV+CLK_DIV cycles, where NBITS = WIDTH (+1 with parity, REQ-027).
REQ-023 In the done cycle the block SHALL already be in IDLE, so start asserted in that cycle SHALL be accepted (back-to-back frames).
REQ-024 The bit counter SHALL be sized ceil(log2(WIDTH+2)) bits, and the divider counter SHALL be 8 bits, without wrap during a frame.

Reset
REQ-025 On rst=1 at a clk edge the block SHALL go to IDLE with busy=0, done=0, sclk=0, sdata=0, sen=0, counters and shift register cleared, including mid-frame; a start in the same cycle as rst SHALL be ignored.

Configuration
REQ-026 Macro P2S_PARITY_EN SHALL control an optional parity bit.
REQ-027 With P2S_PARITY_EN defined, one extra bit period carrying odd parity over the captured word (bit=1 when the count of ones is even) SHALL follow the data bits, before LATCH.
REQ-028 Without P2S_PARITY_EN, no parity logic SHALL be built and NBITS=WIDTH.

Structure
REQ-029 Package p2s_pkg SHALL hold the state enum (IDLE/SHIFT/LATCH), the CLK_DIV counter width constant and the clog2 helper.
REQ-030 The sclk/bit-period divider SHALL be a sub-module p2s_clkdiv producing a bit-start tick and a phase indication; the FSM and shift register SHALL stay in par2ser_led_drv.

Verification
REQ-031 WIDTH=16, CLK_DIV=2, MSB_FIRST=1, P_in=16'hAA55, start pulse: sdata sampled on sclk rising edges = 1010101001010101; busy high for 66 cycles; sen high for 2 cycles; one done pulse.
REQ-032 Same setup, MSB_FIRST=0: sampled sequence = 1010101001010101 reversed to 1010101001010101 read LSB-first, i.e. bits 0..15 of 16'hAA55 = 1010101001010101 -> check bitwise against P_in[i].
REQ-033 start re-asserted at cycles 10 and 40 of a frame with a different P_in: no effect on the sequence or busy length.
REQ-034 rst asserted at cycle 20 of a frame: all outputs 0 the next cycle, no done pulse; a new start then yields a full, correct frame.
REQ-035 start held high across done: a second frame begins the cycle after done, with a 0-cycle idle gap.
REQ-036 P2S_PARITY_EN defined, P_in=16'hAA55 (8 ones): a 17th bit = 1 is sampled; busy length = 17*4+2 = 70 cycles.
